tx_fifo_arbiter: RTL and testbench

TX_FIFO_ARBITER -- requirements
Module: tx_fifo_arbiter

---
 rtl/tx_fifo_arbiter.sv | 95 +++++++++
 tb/tb_tx_fifo_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that serialises register bytes and 16-bit ALU results
// into a byte-wide FIFO write port, stalling cleanly on fifo_full.
module tx_fifo_arbiter #(
  parameter int unsigned data_width = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rg_req,
  input  logic [data_width-1:0]     rg_data,
  output logic                      rg_ack,
  input  logic                      alu_req,
  input  logic [2*data_width-1:0]   alu_data,
  output logic                      alu_ack,
  input  logic                      fifo_full,
  output logic                      w_inc,
  output logic [data_width-1:0]     wr_data,
  output logic                      busy
);

  localparam int unsigned alu_width = 2 * data_width;
  localparam logic grant_rg  = 1'b0;
  localparam logic grant_alu = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_RG = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [alu_width-1:0]   hold, hold_nxt;
  logic                   last_grant, last_grant_nxt;

  // State, hold register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      last_grant <= grant_alu;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Grant, serialisation and FIFO strobe; everything is silenced while rst is high
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    last_grant_nxt = last_grant;
    rg_ack         = 1'b0;
    alu_ack        = 1'b0;
    w_inc          = 1'b0;
    wr_data        = '0;
    busy           = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          // On a tie the requester not granted last wins
          if (rg_req && (!alu_req || last_grant == grant_alu)) begin
            rg_ack         = 1'b1;
            hold_nxt       = alu_width'(rg_data);
            last_grant_nxt = grant_rg;
            state_nxt      = SEND_RG;
          end else if (alu_req) begin
            alu_ack        = 1'b1;
            hold_nxt       = alu_data;
            last_grant_nxt = grant_alu;
            state_nxt      = SEND_LO;
          end
        end
        SEND_RG: begin
          wr_data = hold[data_width-1:0];
          w_inc   = !fifo_full;
          if (!fifo_full) state_nxt = IDLE;
        end
        SEND_LO: begin
          wr_data = hold[data_width-1:0];
          w_inc   = !fifo_full;
          if (!fifo_full) state_nxt = SEND_HI;
        end
        SEND_HI: begin
          wr_data = hold[alu_width-1:data_width];
          w_inc   = !fifo_full;
          if (!fifo_full) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Bench for tx_fifo_arbiter: directed scenarios plus random traffic, all
// checked against a byte-queue model of the expected FIFO write stream.
module tb_tx_fifo_arbiter;

  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            rg_req;
  logic [DW-1:0]   rg_data;
  logic            rg_ack;
  logic            alu_req;
  logic [2*DW-1:0] alu_data;
  logic            alu_ack;
  logic            fifo_full;
  logic            w_inc;
  logic [DW-1:0]   wr_data;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes still owed to the FIFO, and who won the last grant
  logic [DW-1:0] pend_q[$];
  logic          m_last_alu;

  tx_fifo_arbiter #(.data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .rg_req(rg_req), .rg_data(rg_data), .rg_ack(rg_ack),
    .alu_req(alu_req), .alu_data(alu_data), .alu_ack(alu_ack),
    .fifo_full(fifo_full), .w_inc(w_inc), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
  task automatic cycle(input logic r, input logic rq, input logic [DW-1:0] rd,
                       input logic aq, input logic [2*DW-1:0] ad, input logic f,
                       output logic g_rg, output logic g_alu);
    logic e_busy, e_winc;
    logic [DW-1:0] e_wr;
    rst = r; rg_req = rq; rg_data = rd; alu_req = aq; alu_data = ad; fifo_full = f;
    g_rg = 1'b0; g_alu = 1'b0;
    e_busy = 1'b0; e_winc = 1'b0; e_wr = '0;
    if (!r) begin
      if (pend_q.size() == 0) begin
        if (rq && aq) begin
          g_rg = m_last_alu; g_alu = !m_last_alu;
        end else begin
          g_rg = rq; g_alu = aq;
        end
      end else begin
        e_busy = 1'b1;
        e_wr   = pend_q[0];
        e_winc = !f;
      end
    end
    @(negedge clk);
    check("rg_ack",  32'(rg_ack),  32'(g_rg));
    check("alu_ack", 32'(alu_ack), 32'(g_alu));
    check("w_inc",   32'(w_inc),   32'(e_winc));
    check("wr_data", 32'(wr_data), 32'(e_wr));
    check("busy",    32'(busy),    32'(e_busy));
    @(posedge clk);
    if (r) begin
      pend_q.delete();
      m_last_alu = 1'b1;
    end else if (g_rg) begin
      pend_q.push_back(rd);
      m_last_alu = 1'b0;
    end else if (g_alu) begin
      pend_q.push_back(ad[DW-1:0]);
      pend_q.push_back(ad[2*DW-1:DW]);
      m_last_alu = 1'b1;
    end else if (pend_q.size() != 0 && !f) begin
      void'(pend_q.pop_front());
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, a, b);
  endtask

  logic            ga, gb;
  logic            r_rq, r_aq;
  logic [DW-1:0]   r_rd;
  logic [2*DW-1:0] r_ad;

  initial begin
    m_last_alu = 1'b1;
    rst = 1'b1; rg_req = 1'b0; rg_data = '0; alu_req = 1'b0; alu_data = '0; fifo_full = 1'b0;
    @(posedge clk); #1;

    // Reset with requests present: no acks, nothing written
    cycle(1'b1, 1'b1, 8'hAA, 1'b1, 16'h5555, 1'b0, ga, gb);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, ga, gb);

    // Single register byte
    cycle(1'b0, 1'b1, 8'h5A, 1'b0, '0, 1'b0, ga, gb);
    idle(3);

    // Single ALU result
    cycle(1'b0, 1'b0, '0, 1'b1, 16'h1234, 1'b0, ga, gb);
    idle(4);

    // Both held continuously after reset: rg first, then alternate
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, ga, gb);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'h77, 1'b1, 16'hA1B2, 1'b0, ga, gb);
    idle(4);

    // Stall for three cycles in the MSB phase
    cycle(1'b0, 1'b0, '0, 1'b1, 16'hBEEF, 1'b0, ga, gb);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, ga, gb);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, ga, gb);
    idle(3);

    // Reset during the MSB phase abandons it
    cycle(1'b0, 1'b0, '0, 1'b1, 16'h1234, 1'b0, ga, gb);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, ga, gb);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, ga, gb);
    idle(3);

    // Register request arriving mid-ALU waits for the whole result
    cycle(1'b0, 1'b0, '0, 1'b1, 16'h4321, 1'b0, ga, gb);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hC3, 1'b0, '0, 1'b0, ga, gb);
    idle(3);

    // Request dropped before being granted leaves no trace
    cycle(1'b0, 1'b0, '0, 1'b1, 16'h0F0F, 1'b0, ga, gb);
    cycle(1'b0, 1'b1, 8'h99, 1'b0, '0, 1'b1, ga, gb);
    idle(4);

    // Random traffic with stalls, drops and occasional resets
    r_rq = 1'b0; r_aq = 1'b0; r_rd = '0; r_ad = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r, f;
      if (!r_rq && ($urandom % 4) == 0) begin r_rq = 1'b1; r_rd = DW'($urandom); end
      else if (r_rq && ($urandom % 24) == 0) r_rq = 1'b0;
      if (!r_aq && ($urandom % 4) == 0) begin r_aq = 1'b1; r_ad = (2*DW)'($urandom); end
      else if (r_aq && ($urandom % 24) == 0) r_aq = 1'b0;
      r = (($urandom % 250) == 0);
      f = (($urandom % 3) == 0);
      cycle(r, r_rq, r_rd, r_aq, r_ad, f, ga, gb);
      if (ga) r_rq = 1'b0;
      if (gb) r_aq = 1'b0;
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
